// File: rtl/defuse_session_ctrl_if.sv
// Handshake bundle between the round controller and its surroundings:
// player submissions, game status outputs and the UART status-frame link.
interface defuse_session_ctrl_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int CODE_W      = 14
);
    logic                          start;
    logic                          restart;
    logic [NUM_PLAYERS-1:0]        guess_valid;
    logic [NUM_PLAYERS*CODE_W-1:0] guess;
    logic [2:0]                    state;
    logic [CODE_W-1:0]             code;
    logic [NUM_PLAYERS-1:0]        player_ok;
    logic [7:0]                    secs_left;
    logic [3:0]                    strikes;
    logic                          tx_valid;
    logic [15:0]                   tx_data;
    logic                          tx_ready;

    modport master (
        output start, restart, guess_valid, guess, tx_ready,
        input  state, code, player_ok, secs_left, strikes, tx_valid, tx_data
    );

    modport slave (
        input  start, restart, guess_valid, guess, tx_ready,
        output state, code, player_ok, secs_left, strikes, tx_valid, tx_data
    );
endinterface

// File: rtl/defuse_session_ctrl.sv
// Bomb-defusal round controller: LFSR code generation, per-player guess checks,
// countdown, strike counting and a latest-wins status frame buffer for the UART.
module defuse_guess_cmp #(
    parameter int CODE_W = 14
) (
    input  logic              i_vld,
    input  logic [CODE_W-1:0] i_guess,
    input  logic [CODE_W-1:0] i_code,
    output logic              o_hit,
    output logic              o_miss
);
    assign o_hit  = i_vld && (i_guess == i_code);
    assign o_miss = i_vld && (i_guess != i_code);
endmodule

module defuse_session_ctrl #(
    parameter int          NUM_PLAYERS = 2,
    parameter int          CODE_W      = 14,
    parameter int          CODE_MAX    = 9999,
    parameter int          TICK_DIV    = 100_000_000,
    parameter int          ROUND_SECS  = 60,
    parameter int          MAX_STRIKES = 3,
    parameter logic [31:0] LFSR_SEED   = 32'd12345
) (
    input  logic                  basys_clk,
    input  logic                  rst_n,
    defuse_session_ctrl_if.slave  bus
);
    localparam logic [31:0] TAPS = 32'h80200003;
    localparam int          TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMING   = 3'd1,
        S_ACTIVE   = 3'd2,
        S_DEFUSED  = 3'd3,
        S_EXPLODED = 3'd4
    } state_t;

    state_t                 r_state;
    logic [CODE_W-1:0]      r_code;
    logic [NUM_PLAYERS-1:0] r_ok;
    logic [7:0]             r_secs;
    logic [3:0]             r_strk;
    logic [TW-1:0]          r_tick;
    logic [31:0]            r_lfsr;
    logic                   r_txv;
    logic [15:0]            r_txd;

    logic [NUM_PLAYERS-1:0] w_hit;
    logic [NUM_PLAYERS-1:0] w_miss;
    logic [NUM_PLAYERS-1:0] w_ok_nxt;
    logic [4:0]             w_strk_sum;
    logic [3:0]             w_strk_nxt;
    logic                   w_wrap;
    logic [7:0]             w_secs_nxt;
    logic [CODE_W-1:0]      w_cand;
    logic [31:0]            w_cand32;
    logic [31:0]            w_lfsr_nxt;
    logic                   w_to_idle;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            defuse_guess_cmp #(.CODE_W(CODE_W)) u_cmp (
                .i_vld   (bus.guess_valid[gi]),
                .i_guess (bus.guess[gi*CODE_W +: CODE_W]),
                .i_code  (r_code),
                .o_hit   (w_hit[gi]),
                .o_miss  (w_miss[gi])
            );
        end
    endgenerate

    always_comb begin
        w_ok_nxt   = (r_ok | w_hit) & ~w_miss;
        w_strk_sum = {1'b0, r_strk};
        for (int i = 0; i < NUM_PLAYERS; i++)
            w_strk_sum = w_strk_sum + {4'd0, w_miss[i]};
        w_strk_nxt = (w_strk_sum > 5'd15) ? 4'hF : w_strk_sum[3:0];
        w_wrap     = (r_tick == TW'(TICK_DIV - 1));
        w_secs_nxt = (w_wrap && r_secs != 8'd0) ? r_secs - 8'd1 : r_secs;
        w_cand     = r_lfsr[CODE_W-1:0];
        w_cand32   = 32'(w_cand);
        w_lfsr_nxt = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? TAPS : 32'd0);
        w_to_idle  = bus.restart && (r_state != S_IDLE);
    end

    always_ff @(posedge basys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_code  <= '0;
            r_ok    <= '0;
            r_secs  <= 8'(ROUND_SECS);
            r_strk  <= 4'd0;
            r_tick  <= '0;
            r_lfsr  <= LFSR_SEED;
            r_txv   <= 1'b0;
            r_txd   <= 16'd0;
        end else begin
            r_lfsr <= w_lfsr_nxt;
            // Accepted frame drops here; any frame loaded below wins over this.
            if (r_txv && bus.tx_ready)
                r_txv <= 1'b0;

            if (w_to_idle) begin
                r_state <= S_IDLE;
                r_code  <= '0;
                r_ok    <= '0;
                r_secs  <= 8'(ROUND_SECS);
                r_strk  <= 4'd0;
                r_tick  <= '0;
                r_txv   <= 1'b1;
                r_txd   <= 16'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start)
                            r_state <= S_ARMING;
                    end
                    S_ARMING: begin
                        // Rejection sampling keeps the code uniform over 0..CODE_MAX.
                        if (w_cand <= CODE_W'(CODE_MAX)) begin
                            r_code  <= w_cand;
                            r_tick  <= '0;
                            r_state <= S_ACTIVE;
                            r_txv   <= 1'b1;
                            r_txd   <= {2'b01, w_cand32[13:0]};
                        end
                    end
                    S_ACTIVE: begin
                        r_ok   <= w_ok_nxt;
                        r_strk <= w_strk_nxt;
                        r_secs <= w_secs_nxt;
                        r_tick <= w_wrap ? '0 : r_tick + TW'(1);
                        if (&w_ok_nxt) begin
                            r_state <= S_DEFUSED;
                            r_txv   <= 1'b1;
                            r_txd   <= {2'b10, 6'd0, w_secs_nxt};
                        end else if (w_strk_nxt >= 4'(MAX_STRIKES) || w_secs_nxt == 8'd0) begin
                            r_state <= S_EXPLODED;
                            r_txv   <= 1'b1;
                            r_txd   <= {2'b11, 10'd0, w_strk_nxt};
                        end
                    end
                    S_DEFUSED, S_EXPLODED: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.state     = r_state;
    assign bus.code      = r_code;
    assign bus.player_ok = r_ok;
    assign bus.secs_left = r_secs;
    assign bus.strikes   = r_strk;
    assign bus.tx_valid  = r_txv;
    assign bus.tx_data   = r_txd;
endmodule

// File: tb/tb_defuse_session_ctrl.sv
// Directed, table-driven bench for defuse_session_ctrl with small round parameters.
module tb_defuse_session_ctrl;
    localparam int NP = 2;
    localparam int CW = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    defuse_session_ctrl_if #(.NUM_PLAYERS(NP), .CODE_W(CW)) bus ();

    defuse_session_ctrl #(
        .NUM_PLAYERS(NP), .CODE_W(CW), .CODE_MAX(9999), .TICK_DIV(4),
        .ROUND_SECS(3), .MAX_STRIKES(2), .LFSR_SEED(32'd12345)
    ) dut (
        .basys_clk (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    // Reference LFSR: m_prev is the value the DUT saw before the latest edge.
    logic [31:0] m_lfsr, m_prev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 32'd12345;
            m_prev <= 32'd12345;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h80200003 : 32'd0);
        end
    end

    typedef struct {
        logic        st, rs;
        logic [1:0]  okg, badg;
        logic        rdy;
        logic [2:0]  e_st;
        logic [1:0]  e_ok;
        logic [7:0]  e_secs;
        logic [3:0]  e_strk;
        logic        e_txv;
        logic [15:0] e_txd;
        logic        e_code;
    } vec_t;

    vec_t        q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [13:0] exp_code = '0;

    function automatic vec_t V(input logic st, input logic rs, input logic [1:0] okg,
                               input logic [1:0] badg, input logic rdy, input logic [2:0] es,
                               input logic [1:0] eok, input logic [7:0] esecs,
                               input logic [3:0] estk, input logic etxv,
                               input logic [15:0] etxd, input logic ecode);
        vec_t v;
        v.st = st; v.rs = rs; v.okg = okg; v.badg = badg; v.rdy = rdy;
        v.e_st = es; v.e_ok = eok; v.e_secs = esecs; v.e_strk = estk;
        v.e_txv = etxv; v.e_txd = etxd; v.e_code = ecode;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic [15:0] etxd;
        bus.start   = v.st;
        bus.restart = v.rs;
        bus.tx_ready = v.rdy;
        for (int i = 0; i < NP; i++) begin
            bus.guess_valid[i]    = v.okg[i] | v.badg[i];
            bus.guess[i*CW +: CW] = v.okg[i] ? exp_code : (exp_code ^ 14'h1);
        end
        step();
        bus.start = 1'b0; bus.restart = 1'b0; bus.guess_valid = '0;
        etxd = v.e_code ? {2'b01, exp_code} : v.e_txd;
        chk({tag, ".state"}, 32'(bus.state), 32'(v.e_st));
        chk({tag, ".ok"},    32'(bus.player_ok), 32'(v.e_ok));
        chk({tag, ".secs"},  32'(bus.secs_left), 32'(v.e_secs));
        chk({tag, ".strk"},  32'(bus.strikes), 32'(v.e_strk));
        chk({tag, ".txv"},   32'(bus.tx_valid), 32'(v.e_txv));
        if (v.e_txv) chk({tag, ".txd"}, 32'(bus.tx_data), 32'(etxd));
    endtask

    task automatic run_q(input string tag);
        for (int k = 0; k < q.size(); k++)
            apply(q[k], $sformatf("%s[%0d]", tag, k));
        q.delete();
    endtask

    task automatic arm(input logic rdy);
        bit got = 0;
        bus.tx_ready = rdy;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("arm.state1", 32'(bus.state), 32'd1);
        for (int c = 0; c < 64 && !got; c++) begin
            step();
            if (bus.state == 3'd2) got = 1;
        end
        if (!got) chk("arm.timeout", 32'd0, 32'd1);
        exp_code = m_prev[13:0];
        chk("arm.code",  32'(bus.code), 32'(exp_code));
        chk("arm.range", 32'(bus.code <= 14'd9999), 32'd1);
        chk("arm.txv",   32'(bus.tx_valid), 32'd1);
        chk("arm.txd",   32'(bus.tx_data), 32'({2'b01, exp_code}));
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, ".state"}, 32'(bus.state), 32'd0);
        chk({tag, ".code"},  32'(bus.code), 32'd0);
        chk({tag, ".ok"},    32'(bus.player_ok), 32'd0);
        chk({tag, ".secs"},  32'(bus.secs_left), 32'd3);
        chk({tag, ".strk"},  32'(bus.strikes), 32'd0);
        chk({tag, ".txv"},   32'(bus.tx_valid), 32'd0);
        chk({tag, ".txd"},   32'(bus.tx_data), 32'd0);
    endtask

    task automatic restart_rows();
        q.push_back(V(0,1,2'b00,2'b00,1, 3'd0,2'b00,8'd3,4'd0, 1,16'h0000,0));
        q.push_back(V(0,0,2'b00,2'b00,1, 3'd0,2'b00,8'd3,4'd0, 0,16'h0000,0));
    endtask

    initial begin
        bus.start = 0; bus.restart = 0; bus.guess_valid = '0; bus.guess = '0; bus.tx_ready = 0;
        #12;
        reset_checks("rst");
        rst_n = 1'b1;
        step();

        // Round defused by both players, start ignored, restart frame.
        arm(1'b0);
        q.push_back(V(0,0,2'b00,2'b00,0, 3'd2,2'b00,8'd3,4'd0, 1,16'h0000,1));
        q.push_back(V(0,0,2'b00,2'b00,1, 3'd2,2'b00,8'd3,4'd0, 0,16'h0000,0));
        q.push_back(V(0,0,2'b11,2'b00,0, 3'd3,2'b11,8'd3,4'd0, 1,16'h8003,0));
        q.push_back(V(1,0,2'b00,2'b00,0, 3'd3,2'b11,8'd3,4'd0, 1,16'h8003,0));
        q.push_back(V(0,1,2'b00,2'b00,0, 3'd0,2'b00,8'd3,4'd0, 1,16'h0000,0));
        q.push_back(V(0,0,2'b00,2'b00,1, 3'd0,2'b00,8'd3,4'd0, 0,16'h0000,0));
        run_q("defuse");

        // Timeout: decrements at 4, 8, 12 cycles after entry.
        arm(1'b1);
        for (int k = 1; k <= 12; k++)
            q.push_back(V(0,0,2'b00,2'b00,1, (k == 12) ? 3'd4 : 3'd2, 2'b00,
                          8'(3 - k / 4), 4'd0, (k == 12), 16'hC000, 0));
        restart_rows();
        run_q("timeout");

        // Strikes, explode wins when not all flags set.
        arm(1'b1);
        q.push_back(V(0,0,2'b01,2'b00,1, 3'd2,2'b01,8'd3,4'd0, 0,16'h0000,0));
        q.push_back(V(0,0,2'b00,2'b01,1, 3'd2,2'b00,8'd3,4'd1, 0,16'h0000,0));
        q.push_back(V(0,0,2'b01,2'b10,1, 3'd4,2'b01,8'd3,4'd2, 1,16'hC002,0));
        restart_rows();
        run_q("strikes");

        // Defuse on the same edge the last second expires.
        arm(1'b1);
        for (int k = 1; k <= 11; k++)
            q.push_back(V(0,0,2'b00,2'b00,1, 3'd2,2'b00, 8'(3 - k / 4), 4'd0, 0,16'h0000,0));
        q.push_back(V(0,0,2'b11,2'b00,1, 3'd3,2'b11,8'd0,4'd0, 1,16'h8000,0));
        restart_rows();
        run_q("lastsec");

        // Frame overwrite while tx_ready is held low.
        arm(1'b0);
        q.push_back(V(0,0,2'b00,2'b11,0, 3'd4,2'b00,8'd3,4'd2, 1,16'hC002,0));
        q.push_back(V(0,0,2'b00,2'b00,0, 3'd4,2'b00,8'd3,4'd2, 1,16'hC002,0));
        restart_rows();
        run_q("overwr");

        // Asynchronous reset mid-round, checked before the next clock edge.
        arm(1'b1);
        q.push_back(V(0,0,2'b01,2'b00,1, 3'd2,2'b01,8'd3,4'd0, 0,16'h0000,0));
        run_q("prerst");
        #2 rst_n = 1'b0;
        #1 reset_checks("arst");
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
